// File: rtl/breakout_pkg.sv
// Shared constants and types for the breakout brick-hit arbiter.
package breakout_pkg;

  localparam logic [1:0] HIT_NONE   = 2'b00;
  localparam logic [1:0] HIT_V      = 2'b01;
  localparam logic [1:0] HIT_H      = 2'b10;
  localparam logic [1:0] HIT_CORNER = 2'b11;

  localparam int unsigned          SCORE_W   = 9;
  localparam logic [SCORE_W-1:0]   SCORE_MAX = 9'd511;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    REPORT
  } state_e;

endpackage

// File: rtl/hit_popcount.sv
// Combinational population count of a masked brick vector.
module hit_popcount #(
  parameter int unsigned N_BLOCKS = 8
) (
  input  logic [N_BLOCKS-1:0]              i_vec,
  input  logic [N_BLOCKS-1:0]              i_mask,
  output logic [$clog2(N_BLOCKS + 1)-1:0]  o_count
);

  localparam int unsigned CNT_W = $clog2(N_BLOCKS + 1);

  always_comb begin
    o_count = '0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      o_count = o_count + CNT_W'(i_vec[k] & i_mask[k]);
    end
  end

endmodule

// File: rtl/brick_hit_arbiter.sv
// Collects brick hit codes, acknowledges them, and turns them into flip pulses,
// score and brick-count updates.
module brick_hit_arbiter
  import breakout_pkg::*;
#(
  parameter int unsigned  N_BLOCKS      = 8,
  parameter int unsigned  PTS_PER_BLOCK = 1,
  localparam int unsigned CNT_W         = $clog2(N_BLOCKS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [2*N_BLOCKS-1:0]  i_hit_vec,
  output logic                   o_col_detected,
  output logic                   o_flip_x,
  output logic                   o_flip_y,
  output logic [SCORE_W-1:0]     o_score,
  output logic [CNT_W-1:0]       o_bricks_left,
  output logic                   o_endgame
);

  state_e               r_state, w_state_d;
  logic [N_BLOCKS-1:0]  r_mask, w_mask_d;
  logic [1:0]           r_code, w_code_d;
  logic [CNT_W-1:0]     r_count, w_count_d;
  logic                 r_col, w_col_d;
  logic                 r_flip_x, w_flip_x_d;
  logic                 r_flip_y, w_flip_y_d;
  logic [SCORE_W-1:0]   r_score, w_score_d;
  logic [CNT_W-1:0]     r_left, w_left_d;
  logic                 r_end, w_end_d;

  logic [N_BLOCKS-1:0]  w_nz;
  logic [1:0]           w_code_or;
  logic [1:0]           w_delta_or;
  logic [CNT_W-1:0]     w_snap_cnt;
  logic [CNT_W-1:0]     w_delta_cnt;
  logic [CNT_W:0]       w_total;
  logic [1:0]           w_code_fin;
  logic [31:0]          w_score_sum;

  always_comb begin
    w_nz       = '0;
    w_code_or  = HIT_NONE;
    w_delta_or = HIT_NONE;
    for (int k = 0; k < N_BLOCKS; k++) begin
      w_nz[k]   = (i_hit_vec[2*k +: 2] != HIT_NONE);
      w_code_or = w_code_or | i_hit_vec[2*k +: 2];
      if (!r_mask[k]) begin
        w_delta_or = w_delta_or | i_hit_vec[2*k +: 2];
      end
    end
  end

  hit_popcount #(
    .N_BLOCKS (N_BLOCKS)
  ) u_pop_snap (
    .i_vec   (w_nz),
    .i_mask  ({N_BLOCKS{1'b1}}),
    .o_count (w_snap_cnt)
  );

  // Bricks that latched a hit during the acknowledge window, not yet counted.
  hit_popcount #(
    .N_BLOCKS (N_BLOCKS)
  ) u_pop_delta (
    .i_vec   (w_nz),
    .i_mask  (~r_mask),
    .o_count (w_delta_cnt)
  );

  assign w_total     = {1'b0, r_count} + {1'b0, w_delta_cnt};
  assign w_code_fin  = r_code | w_delta_or;
  assign w_score_sum = 32'(r_score) + 32'(w_total) * PTS_PER_BLOCK;

  always_comb begin
    w_state_d  = r_state;
    w_mask_d   = r_mask;
    w_code_d   = r_code;
    w_count_d  = r_count;
    w_col_d    = 1'b0;
    w_flip_x_d = 1'b0;
    w_flip_y_d = 1'b0;
    w_score_d  = r_score;
    w_left_d   = r_left;
    w_end_d    = r_end;
    unique case (r_state)
      IDLE: begin
        if (|w_nz) begin
          w_mask_d  = w_nz;
          w_code_d  = w_code_or;
          w_count_d = w_snap_cnt;
          w_col_d   = 1'b1;
          w_state_d = ACK;
        end
      end
      ACK: begin
        w_code_d   = w_code_fin;
        w_flip_x_d = w_code_fin[1];
        w_flip_y_d = w_code_fin[0];
        w_state_d  = REPORT;
        if (!r_end) begin
          w_score_d = (w_score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
          if (w_total >= {1'b0, r_left}) begin
            w_left_d = '0;
            w_end_d  = 1'b1;
          end else begin
            w_left_d = r_left - w_total[CNT_W-1:0];
          end
        end
      end
      REPORT: begin
        w_mask_d  = '0;
        w_code_d  = HIT_NONE;
        w_count_d = '0;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_start) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_code   <= HIT_NONE;
      r_count  <= '0;
      r_col    <= 1'b0;
      r_flip_x <= 1'b0;
      r_flip_y <= 1'b0;
      r_score  <= '0;
      r_left   <= CNT_W'(N_BLOCKS);
      r_end    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_mask   <= w_mask_d;
      r_code   <= w_code_d;
      r_count  <= w_count_d;
      r_col    <= w_col_d;
      r_flip_x <= w_flip_x_d;
      r_flip_y <= w_flip_y_d;
      r_score  <= w_score_d;
      r_left   <= w_left_d;
      r_end    <= w_end_d;
    end
  end

  assign o_col_detected = r_col;
  assign o_flip_x       = r_flip_x;
  assign o_flip_y       = r_flip_y;
  assign o_score        = r_score;
  assign o_bricks_left  = r_left;
  assign o_endgame      = r_end;

endmodule

// File: tb/tb_brick_hit_arbiter.sv
// Directed self-checking bench for brick_hit_arbiter (default and high-score instances).
module tb_brick_hit_arbiter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] hit;
  logic [15:0] hit_s;

  logic       col, fx, fy, endg;
  logic [8:0] score;
  logic [3:0] left;
  logic       col_s, fx_s, fy_s, endg_s;
  logic [8:0] score_s;
  logic [3:0] left_s;

  int checks = 0;
  int errors = 0;

  brick_hit_arbiter #(
    .N_BLOCKS      (8),
    .PTS_PER_BLOCK (1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_hit_vec      (hit),
    .o_col_detected (col),
    .o_flip_x       (fx),
    .o_flip_y       (fy),
    .o_score        (score),
    .o_bricks_left  (left),
    .o_endgame      (endg)
  );

  brick_hit_arbiter #(
    .N_BLOCKS      (8),
    .PTS_PER_BLOCK (255)
  ) dut_sat (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_hit_vec      (hit_s),
    .o_col_detected (col_s),
    .o_flip_x       (fx_s),
    .o_flip_y       (fy_s),
    .o_score        (score_s),
    .o_bricks_left  (left_s),
    .o_endgame      (endg_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot of the default instance.
  task automatic chk_all(input string tag, input logic c, input logic x, input logic y,
                         input int s, input int l, input logic e);
    chk({tag, ".col"},   32'(col),   32'(c));
    chk({tag, ".fx"},    32'(fx),    32'(x));
    chk({tag, ".fy"},    32'(fy),    32'(y));
    chk({tag, ".score"}, 32'(score), 32'(s));
    chk({tag, ".left"},  32'(left),  32'(l));
    chk({tag, ".end"},   32'(endg),  32'(e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hit   = '0;
    hit_s = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    hit   = '0;
    hit_s = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_all("reset", 0, 0, 0, 0, 8, 0);
    chk("reset.sat_score", 32'(score_s), 32'd0);

    // Single vertical hit on brick 3
    hit = 16'h0040;
    tick();
    chk_all("single.e0", 1, 0, 0, 0, 8, 0);
    hit = '0;
    tick();
    chk_all("single.e1", 0, 0, 1, 1, 7, 0);
    tick();
    chk_all("single.e2", 0, 0, 0, 1, 7, 0);

    // Simultaneous hits: brick 0 horizontal, brick 5 vertical
    do_reset();
    hit = 16'h0402;
    tick();
    chk_all("simul.e0", 1, 0, 0, 0, 8, 0);
    hit = '0;
    tick();
    chk_all("simul.e1", 0, 1, 1, 2, 6, 0);
    tick();
    chk_all("simul.e2", 0, 0, 0, 2, 6, 0);

    // Late hit on brick 6 during ACK, then a hit held through REPORT
    do_reset();
    hit = 16'h0010;
    tick();
    chk_all("late.e0", 1, 0, 0, 0, 8, 0);
    hit = 16'h2000;
    tick();
    chk_all("late.e1", 0, 1, 1, 2, 6, 0);
    hit = 16'h0008;
    tick();
    chk_all("report_hold.e2", 0, 0, 0, 2, 6, 0);
    tick();
    chk_all("report_hold.e3", 1, 0, 0, 2, 6, 0);
    hit = '0;
    tick();
    chk_all("report_hold.e4", 0, 1, 0, 3, 5, 0);
    tick();
    chk_all("report_hold.e5", 0, 0, 0, 3, 5, 0);

    // Clear seven bricks, then the last one, then hit after endgame
    do_reset();
    hit = 16'h1555;
    tick();
    hit = '0;
    tick();
    chk_all("seven.e1", 0, 0, 1, 7, 1, 0);
    tick();
    hit = 16'hC000;
    tick();
    hit = '0;
    tick();
    chk_all("last.e1", 0, 1, 1, 8, 0, 1);
    tick();
    hit = 16'h0001;
    tick();
    chk_all("post_end.e0", 1, 0, 0, 8, 0, 1);
    hit = '0;
    tick();
    chk_all("post_end.e1", 0, 0, 1, 8, 0, 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start_clear", 0, 0, 0, 0, 8, 0);

    // Score saturation on the 255-point instance
    do_reset();
    hit_s = 16'h0005;
    tick();
    chk("sat.pre.col", 32'(col_s), 32'd1);
    hit_s = '0;
    tick();
    chk("sat.pre.score", 32'(score_s), 32'd510);
    chk("sat.pre.left", 32'(left_s), 32'd6);
    tick();
    hit_s = 16'h0150;
    tick();
    hit_s = '0;
    tick();
    chk("sat.score", 32'(score_s), 32'd511);
    chk("sat.left", 32'(left_s), 32'd3);
    chk("sat.flips", {30'd0, fx_s, fy_s}, 32'd1);
    chk("sat.other_idle", 32'(score), 32'd0);

    // Reset during ACK drops the hit
    do_reset();
    hit = 16'h0040;
    tick();
    chk_all("rst_ack.e0", 1, 0, 0, 0, 8, 0);
    rst_n = 1'b0;
    hit   = '0;
    tick();
    chk_all("rst_ack.e1", 0, 0, 0, 0, 8, 0);
    rst_n = 1'b1;
    tick();
    chk_all("rst_ack.e2", 0, 0, 0, 0, 8, 0);

    // Start during ACK drops the hit
    hit = 16'h0040;
    tick();
    chk_all("start_ack.e0", 1, 0, 0, 0, 8, 0);
    start = 1'b1;
    hit   = '0;
    tick();
    start = 1'b0;
    chk_all("start_ack.e1", 0, 0, 0, 0, 8, 0);
    tick();
    chk_all("start_ack.e2", 0, 0, 0, 0, 8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
